// File: rtl/im2col_stream_if.sv
// ---------------------------------------------------------------------------
// im2col_stream_if
// Handshake bundle for the streaming im2col unit.
//   Input side  : i_pre_valid / o_pre_ready / i_data (one image row per beat)
//   Output side : o_post_valid / i_post_ready / o_data (one KxK window per beat)
//                 plus o_row_last / o_frame_last position markers.
// Modports:
//   slave  - the im2col unit itself
//   master - the surroundings (row source and window sink)
// ---------------------------------------------------------------------------
interface im2col_stream_if #(
    parameter int IMG_W = 28,
    parameter int KSIZE = 3,
    parameter int DW    = 8
);
    logic                              i_pre_valid;
    logic                              o_pre_ready;
    logic [IMG_W-1:0][DW-1:0]          i_data;
    logic                              o_post_valid;
    logic                              i_post_ready;
    logic [KSIZE*KSIZE-1:0][DW-1:0]    o_data;
    logic                              o_row_last;
    logic                              o_frame_last;

    modport slave (
        input  i_pre_valid, i_data, i_post_ready,
        output o_pre_ready, o_post_valid, o_data, o_row_last, o_frame_last
    );

    modport master (
        output i_pre_valid, i_data, i_post_ready,
        input  o_pre_ready, o_post_valid, o_data, o_row_last, o_frame_last
    );
endinterface

// File: rtl/im2col_stream.sv
// ---------------------------------------------------------------------------
// im2col_stream
// Streaming im2col: takes an image one pixel row per beat into a KSIZE-row
// circular line buffer and emits one flattened KSIZE x KSIZE window per beat,
// stepping the window origin by STRIDE on both axes.
//
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous active-low reset
//   bus    - im2col_stream_if.slave (row input handshake, window output
//            handshake, row/frame last markers)
//
// Configuration macro: IM2COL_ZERO_PAD_EN
//   defined   : P = (KSIZE-1)/2, taps outside the image read as 0
//   undefined : P = 0, no boundary muxing
// ---------------------------------------------------------------------------
module im2col_stream #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1,
    parameter int DW     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    im2col_stream_if.slave    bus
);

`ifdef IM2COL_ZERO_PAD_EN
    localparam int P = (KSIZE - 1) / 2;
`else
    localparam int P = 0;
`endif
    localparam int OUT_W  = (IMG_W + 2*P - KSIZE) / STRIDE + 1;
    localparam int OUT_H  = (IMG_H + 2*P - KSIZE) / STRIDE + 1;
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int OY_W   = $clog2(OUT_H + 1);
    localparam int OX_W   = $clog2(OUT_W + 1);
    localparam int SLOT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [ROW_W-1:0]  ROWS_MAX  = ROW_W'(IMG_H);
    localparam logic [OY_W-1:0]   OY_LAST   = OY_W'(OUT_H - 1);
    localparam logic [OX_W-1:0]   OX_LAST   = OX_W'(OUT_W - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(KSIZE - 1);

    typedef enum logic [1:0] {S_LOAD, S_EMIT, S_DRAIN} state_t;

    state_t                    r_state;
    logic [ROW_W-1:0]          r_rows_rcvd;
    logic [OY_W-1:0]           r_oy;
    logic [OX_W-1:0]           r_ox;
    logic [SLOT_W-1:0]         r_wslot;     // tracks rows_rcvd % KSIZE
    logic [IMG_W-1:0][DW-1:0]  r_buf [KSIZE];

    logic [ROW_W-1:0]               w_need;
    logic [ROW_W-1:0]               w_rows_inc;
    logic                           w_pre_ready;
    logic                           w_post_valid;
    logic                           w_in_xfer;
    logic                           w_out_xfer;
    logic [KSIZE*KSIZE-1:0][DW-1:0] w_win;

    // Rows that must be resident before output row oy can be emitted.
    always_comb begin
        int v_need;
        v_need = int'(r_oy) * STRIDE - P + KSIZE;
        if (v_need > IMG_H) v_need = IMG_H;
        w_need = ROW_W'(v_need);
    end

    assign w_rows_inc   = r_rows_rcvd + ROW_W'(1);
    assign w_pre_ready  = ((r_state == S_LOAD) && (r_rows_rcvd < w_need)) ||
                          (r_state == S_DRAIN);
    assign w_post_valid = (r_state == S_EMIT);
    assign w_in_xfer    = w_pre_ready && bus.i_pre_valid;
    assign w_out_xfer   = w_post_valid && bus.i_post_ready;

    // Window gather: image row y lives in slot y % KSIZE.
    always_comb begin
        int v_y;
        int v_x;
        w_win = '0;
        v_y   = 0;
        v_x   = 0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                v_y = int'(r_oy) * STRIDE + r - P;
                v_x = int'(r_ox) * STRIDE + c - P;
`ifdef IM2COL_ZERO_PAD_EN
                if ((v_y >= 0) && (v_y < IMG_H) && (v_x >= 0) && (v_x < IMG_W))
                    w_win[r*KSIZE+c] = r_buf[SLOT_W'(v_y % KSIZE)][XW'(v_x)];
`else
                w_win[r*KSIZE+c] = r_buf[SLOT_W'(v_y % KSIZE)][XW'(v_x)];
`endif
            end
        end
    end

    assign bus.o_pre_ready  = w_pre_ready;
    assign bus.o_post_valid = w_post_valid;
    assign bus.o_data       = w_win;
    assign bus.o_row_last   = w_post_valid && (r_ox == OX_LAST);
    assign bus.o_frame_last = w_post_valid && (r_ox == OX_LAST) && (r_oy == OY_LAST);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_LOAD;
            r_rows_rcvd <= '0;
            r_oy        <= '0;
            r_ox        <= '0;
            r_wslot     <= '0;
            for (int k = 0; k < KSIZE; k++) r_buf[k] <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_xfer) begin
                        r_buf[r_wslot] <= bus.i_data;
                        r_rows_rcvd    <= w_rows_inc;
                        r_wslot        <= (r_wslot == SLOT_LAST) ? '0 : r_wslot + SLOT_W'(1);
                        if (w_rows_inc >= w_need) r_state <= S_EMIT;
                    end else if (r_rows_rcvd >= w_need) begin
                        // clamped need at the bottom edge: rows already resident
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_out_xfer) begin
                        if (r_ox == OX_LAST) begin
                            r_ox <= '0;
                            if (r_oy == OY_LAST) begin
                                if (r_rows_rcvd < ROWS_MAX) begin
                                    r_state <= S_DRAIN;
                                end else begin
                                    r_state     <= S_LOAD;
                                    r_rows_rcvd <= '0;
                                    r_oy        <= '0;
                                    r_wslot     <= '0;
                                end
                            end else begin
                                r_oy    <= r_oy + OY_W'(1);
                                r_state <= S_LOAD;
                            end
                        end else begin
                            r_ox <= r_ox + OX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // stride remainder rows are consumed but never stored
                    if (w_in_xfer) begin
                        if (w_rows_inc == ROWS_MAX) begin
                            r_state     <= S_LOAD;
                            r_rows_rcvd <= '0;
                            r_oy        <= '0;
                            r_ox        <= '0;
                            r_wslot     <= '0;
                        end else begin
                            r_rows_rcvd <= w_rows_inc;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_im2col_stream.sv
module tb_im2col_stream;

`ifdef IM2COL_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
    localparam logic [127:0] W0_EXP  = 128'h1D1C00010000000000;
    localparam logic [127:0] W11_EXP = 128'h18171611100F0A0908;
    localparam int           OW2     = 4;
`else
    localparam bit PAD = 1'b0;
    localparam logic [127:0] W0_EXP  = 128'h3A39381E1D1C020100;
    localparam logic [127:0] W11_EXP = 128'h201F1E191817121110;
    localparam int           OW2     = 3;
`endif

    logic clk;
    logic tb_rst_n;
    logic tb_pre_valid;
    logic tb_post_ready;
    logic sel;
    int   tb_row;
    int   tb_seed;
    int   total;
    int   bad;
    logic [127:0] cap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    im2col_stream_if #(.IMG_W(28), .KSIZE(3), .DW(8)) b1 ();
    im2col_stream_if #(.IMG_W(7),  .KSIZE(3), .DW(8)) b2 ();

    im2col_stream #(.IMG_W(28), .IMG_H(28), .KSIZE(3), .STRIDE(1), .DW(8)) dut1 (
        .i_clk (clk),
        .i_rst (tb_rst_n),
        .bus   (b1)
    );

    im2col_stream #(.IMG_W(7), .IMG_H(8), .KSIZE(3), .STRIDE(2), .DW(8)) dut2 (
        .i_clk (clk),
        .i_rst (tb_rst_n),
        .bus   (b2)
    );

    assign b1.i_pre_valid  = !sel && tb_pre_valid;
    assign b1.i_post_ready = !sel && tb_post_ready;
    assign b2.i_pre_valid  = sel && tb_pre_valid;
    assign b2.i_post_ready = sel && tb_post_ready;

    always_comb begin
        for (int x = 0; x < 28; x++) b1.i_data[x] = 8'((tb_row * 28 + x + tb_seed) % 256);
    end
    always_comb begin
        for (int x = 0; x < 7; x++) b2.i_data[x] = 8'((tb_row * 7 + x + tb_seed) % 256);
    end

    logic         g_pre_ready, g_post_valid, g_row_last, g_frame_last;
    logic [127:0] g_data;
    assign g_pre_ready  = sel ? b2.o_pre_ready  : b1.o_pre_ready;
    assign g_post_valid = sel ? b2.o_post_valid : b1.o_post_valid;
    assign g_row_last   = sel ? b2.o_row_last   : b1.o_row_last;
    assign g_frame_last = sel ? b2.o_frame_last : b1.o_frame_last;
    assign g_data       = sel ? 128'(b2.o_data) : 128'(b1.o_data);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pre_ready"},  128'(g_pre_ready),  128'(1));
        chk({tag, "_post_valid"}, 128'(g_post_valid), 128'(0));
        chk({tag, "_row_last"},   128'(g_row_last),   128'(0));
        chk({tag, "_frame_last"}, 128'(g_frame_last), 128'(0));
        chk({tag, "_data"},       g_data,             128'(0));
    endtask

    // Drives one frame on the selected DUT and checks every window against
    // pix(y,x) = (y*W + x + seed) % 256 (0 outside the image when padded).
    task automatic run_frame(input int W, input int H, input int K, input int S,
                             input int seed, input bit rnd, input int stop_oy,
                             input int cap_idx, output logic [127:0] cap_o);
        int P, OW, OH, tot, need0, row, win, cyc, acc_cyc, first_v;
        int oy, ox, y, x, v;
        logic [127:0] expw, prev_data;
        bit prev_stall, xin, xout, pr;
        P       = PAD ? (K - 1) / 2 : 0;
        OW      = (W + 2*P - K) / S + 1;
        OH      = (H + 2*P - K) / S + 1;
        tot     = OW * OH;
        need0   = (K - P < H) ? K - P : H;
        row     = 0;
        win     = 0;
        cyc     = 0;
        acc_cyc = -100;
        first_v = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        cap_o      = '0;
        tb_seed    = seed;
        while (!(win == tot && row == H) && cyc < 20000) begin
            tb_row        = (row < H) ? row : H - 1;
            tb_pre_valid  = (row < H);
            pr            = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tb_post_ready = pr;
            #1;
            chk("excl", 128'(g_pre_ready & g_post_valid), 128'(0));
            if (prev_stall) chk("stall_hold", g_data, prev_data);
            if (g_post_valid) begin
                if (first_v < 0) first_v = cyc;
                oy = win / OW;
                ox = win % OW;
                if (stop_oy >= 0 && oy == stop_oy) return;
                expw = '0;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        y = oy * S - P + r;
                        x = ox * S - P + c;
                        v = (y >= 0 && y < H && x >= 0 && x < W) ? (y * W + x + seed) % 256 : 0;
                        expw[8*(r*K+c) +: 8] = 8'(v);
                    end
                end
                chk("window", g_data, expw);
                chk("flags", {126'b0, g_row_last, g_frame_last},
                    {126'b0, (ox == OW - 1), (win == tot - 1)});
                if (win == cap_idx) cap_o = g_data;
            end
            xin        = g_pre_ready && tb_pre_valid;
            xout       = g_post_valid && pr;
            prev_stall = g_post_valid && !pr;
            prev_data  = g_data;
            @(posedge clk);
            if (xin) begin
                if (row == need0 - 1) acc_cyc = cyc;
                row++;
            end
            if (xout) win++;
            @(negedge clk);
            cyc++;
        end
        tb_pre_valid  = 1'b0;
        tb_post_ready = 1'b0;
        chk("win_count",     128'(win),               128'(tot));
        chk("rows_taken",    128'(row),               128'(H));
        chk("first_latency", 128'(first_v - acc_cyc), 128'(1));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        sel           = 1'b0;
        tb_rst_n      = 1'b0;
        tb_pre_valid  = 1'b0;
        tb_post_ready = 1'b0;
        tb_row        = 0;
        tb_seed       = 0;

        // reset values, held while reset is asserted
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("rst1");
        sel = 1'b1;
        #1;
        chk_reset_outputs("rst2");
        sel = 1'b0;
        @(negedge clk);
        tb_rst_n = 1'b1;

        // frame A: always-ready sink
        run_frame(28, 28, 3, 1, 0, 1'b0, -1, 0, cap);
        chk("win0_const", cap, W0_EXP);

        // frame B back-to-back, different data, random backpressure
        run_frame(28, 28, 3, 1, 77, 1'b1, -1, 0, cap);

        // reset pulse while output row 10 is being emitted
        run_frame(28, 28, 3, 1, 0, 1'b0, 10, 0, cap);
        tb_pre_valid  = 1'b0;
        tb_post_ready = 1'b0;
        #2 tb_rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        tb_rst_n = 1'b1;
        run_frame(28, 28, 3, 1, 0, 1'b1, -1, 0, cap);
        chk("win0_after_rst", cap, W0_EXP);

        // stride 2, 7 wide x 8 high: last row is drained, then a clean frame
        sel = 1'b1;
        @(negedge clk);
        run_frame(7, 8, 3, 2, 0, 1'b1, -1, OW2 + 1, cap);
        chk("win11_const", cap, W11_EXP);
        run_frame(7, 8, 3, 2, 40, 1'b0, -1, 0, cap);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
